// File: rtl/parity_checker_if.sv
// Bit-serial receive link into the running-parity checker.
// The master drives the serial bit and the slave returns the parity status.
interface parity_checker_if;
  logic bit_in;
  logic even_parity;
  logic frame_done;

  modport master (
    output bit_in,
    input  even_parity,
    input  frame_done
  );

  modport slave (
    input  bit_in,
    output even_parity,
    output frame_done
  );
endinterface

// File: rtl/parity_checker.sv
// Serial running-parity checker: tracks whether the count of 1s seen so far is even,
// optionally restarting the count every FRAME_LEN bits and pulsing frame_done on the last bit.
module parity_checker #(
  parameter int unsigned FRAME_LEN = 0,
  parameter int unsigned CNT_W     = 8
) (
  input logic              clk,
  input logic              reset,
  parity_checker_if.slave  link
);

  localparam logic [0:0] S_EVEN = 1'b0;
  localparam logic [0:0] S_ODD  = 1'b1;

  localparam bit              FRAMED   = (FRAME_LEN != 0);
  localparam int unsigned     LAST_IDX = FRAMED ? FRAME_LEN - 1 : 0;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LAST_IDX);

  logic [0:0]       state_q, state_d;
  logic [0:0]       base_state;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             last_bit;

  always_comb begin
    last_bit   = FRAMED && (cnt_q == LAST_CNT);
    // The bit after a frame end toggles from S_EVEN, not from the old frame's parity.
    base_state = done_q ? S_EVEN : state_q;
    state_d    = base_state;
    if (link.bit_in) begin
      state_d = (base_state == S_EVEN) ? S_ODD : S_EVEN;
    end
    cnt_d  = (!FRAMED || last_bit) ? '0 : cnt_q + CNT_W'(1);
    done_d = last_bit;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_EVEN;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign link.even_parity = (state_q == S_EVEN);
  assign link.frame_done  = done_q;

endmodule

// File: tb/tb_parity_checker.sv
// Self-checking bench: an unframed and a 4-bit-framed checker share one bit stream and are
// compared against a frame-queue parity model, with directed vectors and random traffic.
module tb_parity_checker;

  localparam int FrameLen = 4;

  logic clk;
  logic reset;

  parity_checker_if unf_if ();
  parity_checker_if frm_if ();

  parity_checker #(
    .FRAME_LEN (0),
    .CNT_W     (8)
  ) u_unf (
    .clk   (clk),
    .reset (reset),
    .link  (unf_if.slave)
  );

  parity_checker #(
    .FRAME_LEN (FrameLen),
    .CNT_W     (8)
  ) u_frm (
    .clk   (clk),
    .reset (reset),
    .link  (frm_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: total ones since reset, and the bits of the current frame.
  int unf_ones;
  bit frm_bits[$];

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    unf_ones = 0;
    frm_bits.delete();
  endtask

  task automatic check_outputs(input string tag);
    int  frm_ones;
    bit  frm_full;
    frm_ones = 0;
    foreach (frm_bits[i]) frm_ones += int'(frm_bits[i]);
    frm_full = (frm_bits.size() == FrameLen);
    check({tag, "_unf_par"},  unf_if.even_parity, logic'((unf_ones % 2) == 0));
    check({tag, "_unf_done"}, unf_if.frame_done,  1'b0);
    check({tag, "_frm_par"},  frm_if.even_parity, logic'((frm_ones % 2) == 0));
    check({tag, "_frm_done"}, frm_if.frame_done,  logic'(frm_full));
    if (frm_full) frm_bits.delete();
  endtask

  task automatic step(input logic b, input string tag);
    unf_if.bit_in = b;
    frm_if.bit_in = b;
    @(posedge clk);
    #1;
    unf_ones += int'(b);
    frm_bits.push_back(b);
    check_outputs(tag);
  endtask

  task automatic hold_reset(input int cycles);
    reset = 1'b0;
    model_reset();
    #1;
    check_outputs("rst_async");
    repeat (cycles) begin
      unf_if.bit_in = 1'b1;
      frm_if.bit_in = 1'b1;
      @(posedge clk);
      #1;
      check_outputs("rst_hold");
    end
    reset = 1'b1;
  endtask

  logic t2_bits [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
  logic t2_par  [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic t4_bits [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  logic t4_done [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    reset         = 1'b1;
    unf_if.bit_in = 1'b0;
    frm_if.bit_in = 1'b0;
    model_reset();
    #2;

    // Reset held for two cycles with bit_in high must not move anything.
    hold_reset(2);

    // Unframed reference vector.
    for (int i = 0; i < 6; i++) begin
      step(t2_bits[i], "t2");
      check("t2_vec_par", unf_if.even_parity, t2_par[i]);
    end

    // Long run of zeros keeps parity even; one 1 flips it.
    hold_reset(1);
    for (int i = 0; i < 8; i++) step(1'b0, "t3_zero");
    check("t3_zeros_par", unf_if.even_parity, 1'b1);
    step(1'b1, "t3_one");
    check("t3_one_par", unf_if.even_parity, 1'b0);

    // Framed: two frames, with restart from even at frame 2.
    hold_reset(1);
    for (int i = 0; i < 8; i++) begin
      step(t4_bits[i], "t4");
      check("t4_vec_done", frm_if.frame_done, t4_done[i]);
      if (i == 3) check("t4_f1_par", frm_if.even_parity, 1'b0);
      if (i == 4) check("t4_restart_par", frm_if.even_parity, 1'b0);
      if (i == 7) check("t4_f2_par", frm_if.even_parity, 1'b1);
    end

    // Asynchronous reset mid-frame while odd, between clock edges.
    hold_reset(1);
    step(1'b1, "t5_pre");
    step(1'b0, "t5_pre");
    check("t5_odd_before", frm_if.even_parity, 1'b0);
    #3;
    reset = 1'b0;
    #1;
    model_reset();
    check("t5_async_par", frm_if.even_parity, 1'b1);
    check_outputs("t5_async");
    #2;
    reset = 1'b1;
    for (int i = 0; i < FrameLen; i++) begin
      step(1'b1, "t5_post");
      check("t5_post_done", frm_if.frame_done, logic'(i == FrameLen - 1));
    end

    // Random traffic with occasional mid-cycle asynchronous resets.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_outputs("rnd_rst");
        #2;
        reset = 1'b1;
      end
      step(logic'($urandom_range(0, 1)), "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
